mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single RAM port between the fetch-stage instruction requester and the memory-stage data requester. Data accesses normally win, and a bounded-starvation counter guarantees that fetch eventually gets the port. The block latches the address and store data at grant, holds the RAM request stable until `ramready`, and returns registered load data with a one-cycle completion pulse. It sits between the datapath's request/wait signals and the RAM model.

## Interface
- `STARVE_MAX`, default 4: maximum consecutive data grants issued while `iREN` is pending before fetch is forced to win. Legal range 1–15.
- `CLK` in 1: the single clock; all state changes on the rising edge.
- `RST` in 1: reset is synchronous and active-high.
- `iREN` in 1: instruction read request; held until `iwait` drops.
- `iaddr` in 32: instruction address.
- `iload` out 32: instruction read data, valid when `iwait`=0.
- `iwait` out 1: 1 = instruction access not complete.
- `dREN` in 1: data read request.
- `dWEN` in 1: data write request.
- `daddr` in 32: data address.
- `dstore` in 32: data to write.
- `dload` out 32: data read data, valid when `dwait`=0.
- `dwait` out 1: 1 = data access not complete.
- `ramREN` out 1: RAM read request.
- `ramWEN` out 1: RAM write request.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data.
- `ramready` in 1: RAM access completes this cycle.

## Operation
- FSM states: IDLE, IACC, DACC, IDONE, DDONE. Reset state is IDLE.
- Arbitration in IDLE:
  - Data request (`dREN|dWEN`) goes to DACC.
  - Exception: when `iREN`=1 and `streak`==`STARVE_MAX`, IACC is chosen instead.
  - Otherwise `iREN`=1 goes to IACC.
  - Otherwise the FSM stays in IDLE.
- Grant latching: on the transition out of IDLE, the block latches:
  - the address (`iaddr` or `daddr`),
  - `dstore`,
  - the operation: read or write. `dWEN` wins if both `dREN` and `dWEN` are 1.
- IACC/DACC:
  - Drive the RAM outputs from the latched values.
  - On `ramready`=1, capture `ramload` into the `iload`/`dload` register (reads only) and go to IDONE/DDONE.
  - Otherwise remain in the state; there is no timeout.
- IDONE/DDONE:
  - The matching wait is 0 for exactly this cycle.
  - The RAM outputs are deasserted.
  - The next state is IDLE.
- `streak` counter, 4-bit, saturating at `STARVE_MAX`:
  - Incremented on a data grant while `iREN`=1.
  - Cleared on an instruction grant, and on a data grant with `iREN`=0.
- Withdrawn request: a request dropped mid-access does not abort the access. The access completes, DONE still pulses, and the result is discarded by the requester. This guarantees writes are never torn.
- `iwait`/`dwait` equal 1 in every state except their own DONE. Waits are also 1 with no request pending.
- `iload`/`dload` hold their last captured value until the next read of that side.

## Timing
- Reset values:
  - state IDLE, `streak`=0;
  - `iwait`=`dwait`=1;
  - `ramREN`=`ramWEN`=0;
  - `ramaddr`=`ramstore`=0;
  - `iload`=`dload`=0.
- Reset asserted mid-access: the access is abandoned, and the RAM outputs are 0 from the next edge.
- Latency for a request seen in IDLE at cycle 0 with `ramready` first high at cycle k (k≥1):
  - RAM request is driven in cycles 1..k;
  - wait is low in cycle k+1;
  - the FSM is back in IDLE at cycle k+2.
- Minimum turnaround is 3 cycles per access; back-to-back grants are never issued without the IDLE cycle.
- `ramready` is ignored outside IACC/DACC.
- Simultaneous `iREN` and data request: data wins unless `streak`==`STARVE_MAX`.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- `MEM_ARBITER_PERF_EN` defined:
  - Adds output ports `igrant_cnt` (32), `dgrant_cnt` (32) and `conflict_cnt` (32).
  - `conflict_cnt` counts IDLE cycles in which both sides request.
  - All three counters are cleared by `RST` and wrap modulo 2^32.
- `MEM_ARBITER_PERF_EN` undefined: the ports and counters are absent, and arbitration behaviour is identical.

## Test plan
- Reset then idle:
  - Stimulus: `RST` high for 2 cycles, then no requests for 10 cycles.
  - Required: waits stay 1, `ramREN`/`ramWEN` stay 0, `ramaddr`=0.
- Instruction read:
  - Stimulus: `iREN`=1, `iaddr`=0x40; `ramready` high on the 3rd cycle of IACC with `ramload`=0x8C220004.
  - Required: `iwait`=0 for exactly one cycle with `iload`=0x8C220004; total latency 5 cycles.
- Data write:
  - Stimulus: `dWEN`=`dREN`=1, `daddr`=0x100, `dstore`=0xDEADBEEF.
  - Required: `ramWEN`=1, `ramREN`=0, `ramaddr`=0x100, `ramstore`=0xDEADBEEF; `dwait` pulses low once.
- Starvation guard:
  - Stimulus: `iREN` and data requests held continuously, `STARVE_MAX`=4, `ramready`=1 always.
  - Required: grant order D,D,D,D,I repeating.
- Withdrawn request:
  - Stimulus: `dWEN` dropped during DACC.
  - Required: the RAM write completes; `ramaddr` stays stable until `ramready`; `dwait` still pulses in DDONE.
- Reset mid-access:
  - Stimulus: `RST` in DACC cycle 2.
  - Required: next cycle IDLE, `ramWEN`=0, `streak`=0; a pending `iREN` is granted afterwards.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, with a bounded-starvation guard for fetch.
// Optional MEM_ARBITER_PERF_EN adds grant and conflict counters.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready
`ifdef MEM_ARBITER_PERF_EN
  ,
  output logic [31:0] igrant_cnt,
  output logic [31:0] dgrant_cnt,
  output logic [31:0] conflict_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, IACC, DACC, IDONE, DDONE} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state, nextState;
  logic [3:0]  streak, nextStreak;
  logic        nextRamREN, nextRamWEN, nextIwait, nextDwait;
  logic [31:0] nextRamaddr, nextRamstore, nextIload, nextDload;
  logic        dReq, grantI, grantD;

  always_comb begin
    dReq   = dREN | dWEN;
    grantI = 1'b0;
    grantD = 1'b0;
    if (state == IDLE) begin
      if (iREN && (streak == STARVE_LIM)) grantI = 1'b1;
      else if (dReq)                      grantD = 1'b1;
      else if (iREN)                      grantI = 1'b1;
    end
  end

  // Outputs are computed one cycle ahead so every output comes straight from a flop.
  always_comb begin
    nextState    = state;
    nextStreak   = streak;
    nextRamREN   = ramREN;
    nextRamWEN   = ramWEN;
    nextRamaddr  = ramaddr;
    nextRamstore = ramstore;
    nextIload    = iload;
    nextDload    = dload;
    nextIwait    = 1'b1;
    nextDwait    = 1'b1;
    case (state)
      IDLE: begin
        if (grantI) begin
          nextState    = IACC;
          nextRamREN   = 1'b1;
          nextRamWEN   = 1'b0;
          nextRamaddr  = iaddr;
          nextRamstore = dstore;
          nextStreak   = 4'd0;
        end else if (grantD) begin
          nextState    = DACC;
          nextRamREN   = ~dWEN;
          nextRamWEN   = dWEN;
          nextRamaddr  = daddr;
          nextRamstore = dstore;
          if (!iREN)                    nextStreak = 4'd0;
          else if (streak < STARVE_LIM) nextStreak = streak + 4'd1;
        end
      end
      IACC, DACC: begin
        if (ramready) begin
          nextState    = (state == IACC) ? IDONE : DDONE;
          nextRamREN   = 1'b0;
          nextRamWEN   = 1'b0;
          nextRamaddr  = 32'd0;
          nextRamstore = 32'd0;
          if (state == IACC) begin
            nextIload = ramload;
            nextIwait = 1'b0;
          end else begin
            if (ramREN) nextDload = ramload;
            nextDwait = 1'b0;
          end
        end
      end
      IDONE, DDONE: nextState = IDLE;
      default:      nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      streak   <= 4'd0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= 32'd0;
      ramstore <= 32'd0;
      iload    <= 32'd0;
      dload    <= 32'd0;
      iwait    <= 1'b1;
      dwait    <= 1'b1;
    end else begin
      state    <= nextState;
      streak   <= nextStreak;
      ramREN   <= nextRamREN;
      ramWEN   <= nextRamWEN;
      ramaddr  <= nextRamaddr;
      ramstore <= nextRamstore;
      iload    <= nextIload;
      dload    <= nextDload;
      iwait    <= nextIwait;
      dwait    <= nextDwait;
    end
  end

`ifdef MEM_ARBITER_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      igrant_cnt   <= 32'd0;
      dgrant_cnt   <= 32'd0;
      conflict_cnt <= 32'd0;
    end else begin
      if (grantI) igrant_cnt <= igrant_cnt + 32'd1;
      if (grantD) dgrant_cnt <= dgrant_cnt + 32'd1;
      if ((state == IDLE) && iREN && dReq) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, every cycle checked against an access-level reference model.
module tb_mem_arbiter;
  localparam int SM = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, ramready = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN;
`ifdef MEM_ARBITER_PERF_EN
  logic [31:0] igrant_cnt, dgrant_cnt, conflict_cnt;
`endif

  mem_arbiter #(.STARVE_MAX(SM)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready)
`ifdef MEM_ARBITER_PERF_EN
    , .igrant_cnt(igrant_cnt), .dgrant_cnt(dgrant_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: an access is a record (side, op, address, data) that lives through
  // a "busy" span until the RAM answers and then one "finishing" cycle.
  typedef struct {
    bit          isInstr;
    bit          isWrite;
    logic [31:0] addr;
    logic [31:0] data;
  } access_t;

  bit          mValid = 0;
  int          mPhase = 0;  // 0 free, 1 waiting on RAM, 2 reporting completion
  int          mStreak = 0;
  access_t     mAcc;
  logic [31:0] eIload = 0, eDload = 0;
  bit          eIdoneNow = 0, eDdoneNow = 0;
  int unsigned mIgrants = 0, mDgrants = 0, mConflicts = 0;

  task automatic modelStep(input logic r, input logic ir, input logic [31:0] ia, input logic dr,
                           input logic dw, input logic [31:0] da, input logic [31:0] ds,
                           input logic rdy, input logic [31:0] rl);
    bit wantD;
    wantD = dr | dw;
    eIdoneNow = 0;
    eDdoneNow = 0;
    if (r) begin
      mPhase = 0; mStreak = 0; eIload = 0; eDload = 0;
      mIgrants = 0; mDgrants = 0; mConflicts = 0;
    end else if (mPhase == 0) begin
      if (ir && wantD) mConflicts++;
      if (ir && (mStreak == SM || !wantD)) begin
        mAcc = '{1'b1, 1'b0, ia, ds};
        mStreak = 0; mPhase = 1; mIgrants++;
      end else if (wantD) begin
        mAcc = '{1'b0, dw, da, ds};
        mStreak = ir ? ((mStreak + 1 > SM) ? SM : mStreak + 1) : 0;
        mPhase = 1; mDgrants++;
      end
    end else if (mPhase == 1) begin
      if (rdy) begin
        if (mAcc.isInstr) begin eIload = rl; eIdoneNow = 1; end
        else begin
          if (!mAcc.isWrite) eDload = rl;
          eDdoneNow = 1;
        end
        mPhase = 2;
      end
    end else begin
      mPhase = 0;
    end
  endtask

  task automatic checkOutputs();
    bit busy;
    busy = (mPhase == 1);
    checkVal("ramREN",   {31'd0, ramREN}, {31'd0, busy && !mAcc.isWrite});
    checkVal("ramWEN",   {31'd0, ramWEN}, {31'd0, busy && mAcc.isWrite});
    checkVal("ramaddr",  ramaddr,  busy ? mAcc.addr : 32'd0);
    checkVal("ramstore", ramstore, busy ? mAcc.data : 32'd0);
    checkVal("iwait",    {31'd0, iwait}, {31'd0, !eIdoneNow});
    checkVal("dwait",    {31'd0, dwait}, {31'd0, !eDdoneNow});
    checkVal("iload",    iload, eIload);
    checkVal("dload",    dload, eDload);
`ifdef MEM_ARBITER_PERF_EN
    checkVal("igrant_cnt",   igrant_cnt,   mIgrants);
    checkVal("dgrant_cnt",   dgrant_cnt,   mDgrants);
    checkVal("conflict_cnt", conflict_cnt, mConflicts);
`endif
  endtask

  // One clock: check the state left by the last edge, then drive the next inputs.
  task automatic cycle(input logic r, input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dw, input logic [31:0] da, input logic [31:0] ds,
                       input logic rdy, input logic [31:0] rl);
    @(negedge CLK);
    if (mValid) checkOutputs();
    RST = r; iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
    daddr = da; dstore = ds; ramready = rdy; ramload = rl;
    modelStep(r, ir, ia, dr, dw, da, ds, rdy, rl);
    mValid = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, $urandom_range(0, 1), $urandom);
  endtask

  initial begin
    bit prevBusy;
    int grantIdx;

    // Reset then idle, with ramready toggling to show it is ignored outside an access.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(10);

    // Instruction read, RAM answers on the third access cycle.
    cycle(0, 1, 32'h40, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h40, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h40, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h40, 0, 0, 0, 0, 1, 32'h8C220004);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Data write with both dREN and dWEN set.
    cycle(0, 0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 0, 0);
    cycle(0, 0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 0, 0);
    cycle(0, 0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 1, 32'h12345678);
    idle(3);

    // Withdrawn write: request and bus inputs change mid-access.
    cycle(0, 0, 0, 0, 1, 32'h200, 32'hCAFEF00D, 0, 0);
    cycle(0, 0, 32'h44, 0, 0, 32'h999, 32'h1111, 0, 0);
    cycle(0, 0, 32'h44, 0, 0, 32'h999, 32'h1111, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);

    // Reset in the second data access cycle, fetch pending throughout.
    cycle(0, 1, 32'h80, 1, 0, 32'h300, 0, 0, 0);
    cycle(0, 1, 32'h80, 1, 0, 32'h300, 0, 0, 0);
    cycle(1, 1, 32'h80, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h80, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h80, 0, 0, 0, 0, 1, 32'hABCD0001);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Starvation guard: both sides saturated, RAM always ready.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    prevBusy = 0;
    grantIdx = 0;
    for (int c = 0; c < 36; c++) begin
      cycle(0, 1, 32'h40, 1, 0, 32'h100, 0, 1, $urandom);
      if ((ramREN | ramWEN) && !prevBusy && grantIdx < 10) begin
        checkVal("grantOrder", ramaddr, (grantIdx % 5 == 4) ? 32'h40 : 32'h100);
        grantIdx++;
      end
      prevBusy = ramREN | ramWEN;
    end
    checkVal("grantCount", grantIdx, 10);

    // Randomized traffic in several load profiles.
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 400; c++) begin
        logic r, ir, dr, dw, rdy;
        r   = (p == 3) ? ($urandom_range(0, 60) == 0) : 1'b0;
        ir  = (p == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
        dr  = (p == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
        dw  = (p == 2) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
        rdy = (p == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
        cycle(r, ir, $urandom, dr, dw, $urandom, $urandom, rdy, $urandom);
      end
    end
    idle(4);
    @(negedge CLK);
    checkOutputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
